// File: rtl/decoder_riscv_pipe_if.sv
// Fetch-side and execute-side handshake bundle
// for the buffered RV32I decoder.
interface decoder_riscv_pipe_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid_i;
  logic            in_ready_o;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_i;
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     dec_instr_o;
  logic [PC_W-1:0] dec_pc_o;
  logic [1:0]      ex_op_a_sel_o;
  logic [2:0]      ex_op_b_sel_o;
  logic [4:0]      alu_op_o;
  logic            mem_req_o;
  logic            mem_we_o;
  logic [2:0]      mem_size_o;
  logic            gpr_we_a_o;
  logic            wb_src_sel_o;
  logic            illegal_instr_o;
  logic            branch_o;
  logic            jal_o;
  logic            jalr_o;
  logic [CW-1:0]   count_o;

  modport master (
    output in_valid_i, instr_i, pc_i,
    output out_ready_i,
    input  in_ready_o, out_valid_o,
    input  dec_instr_o, dec_pc_o,
    input  ex_op_a_sel_o, ex_op_b_sel_o,
    input  alu_op_o, mem_req_o, mem_we_o,
    input  mem_size_o, gpr_we_a_o,
    input  wb_src_sel_o, illegal_instr_o,
    input  branch_o, jal_o, jalr_o,
    input  count_o
  );

  modport slave (
    input  in_valid_i, instr_i, pc_i,
    input  out_ready_i,
    output in_ready_o, out_valid_o,
    output dec_instr_o, dec_pc_o,
    output ex_op_a_sel_o, ex_op_b_sel_o,
    output alu_op_o, mem_req_o, mem_we_o,
    output mem_size_o, gpr_we_a_o,
    output wb_src_sel_o, illegal_instr_o,
    output branch_o, jal_o, jalr_o,
    output count_o
  );
endinterface

// File: rtl/decoder_riscv_pipe.sv
// Buffered RV32I decoder: FIFO of fetched
// instructions feeding a registered decode stage.
module decoder_riscv_pipe #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  decoder_riscv_pipe_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] OP_A_RS1     = 2'd0;
  localparam logic [1:0] OP_A_CURR_PC = 2'd1;
  localparam logic [1:0] OP_A_ZERO    = 2'd2;
  localparam logic [2:0] OP_B_RS2     = 3'd0;
  localparam logic [2:0] OP_B_IMM_I   = 3'd1;
  localparam logic [2:0] OP_B_IMM_U   = 3'd2;
  localparam logic [2:0] OP_B_IMM_S   = 3'd3;
  localparam logic [2:0] OP_B_INCR    = 3'd4;
  localparam logic [4:0] ALU_ADD      = 5'd0;
  localparam logic [2:0] LDST_B       = 3'd0;
  localparam logic       WB_EX        = 1'b0;
  localparam logic       WB_LSU       = 1'b1;

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_MISC   = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  logic [31:0]     instr_q [DEPTH];
  logic [PC_W-1:0] pc_q    [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            full, nonempty;
  logic            in_ready, push, load;
  logic            out_valid;

  logic [31:0]     head;
  logic [6:0]      f7;
  logic [2:0]      f3;
  logic [1:0]      a_sel;
  logic [2:0]      b_sel;
  logic [4:0]      alu;
  logic            mreq, mwe, gwe, wb;
  logic [2:0]      size;
  logic            ill, br, jal, jalr;

  assign full     = (cnt == CW'(DEPTH));
  assign nonempty = (cnt != '0);
  assign in_ready = !full && !rst_i;
  assign push     = bus.in_valid_i && in_ready;
  assign load     = nonempty &&
                    (!out_valid || bus.out_ready_i);

  assign head = instr_q[rd_ptr];
  assign f7   = head[31:25];
  assign f3   = head[14:12];

  // FIFO storage; a push during flush is dropped
  always_ff @(posedge clk_i) begin
    if (push && !flush_i) begin
      instr_q[wr_ptr] <= bus.instr_i;
      pc_q[wr_ptr]    <= bus.pc_i;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (load) rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, load})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Combinational decode of the FIFO head
  always_comb begin
    a_sel = OP_A_RS1;
    b_sel = OP_B_IMM_I;
    alu   = ALU_ADD;
    mreq  = 1'b0;
    mwe   = 1'b0;
    size  = LDST_B;
    gwe   = 1'b0;
    wb    = WB_EX;
    ill   = 1'b0;
    br    = 1'b0;
    jal   = 1'b0;
    jalr  = 1'b0;
    if (head[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      unique case (head[6:2])
        OPC_LOAD: begin
          mreq = 1'b1;
          size = f3;
          gwe  = 1'b1;
          wb   = WB_LSU;
          ill  = (f3 == 3'd3) || (f3 > 3'd5);
        end
        OPC_STORE: begin
          b_sel = OP_B_IMM_S;
          mreq  = 1'b1;
          mwe   = 1'b1;
          size  = f3;
          ill   = (f3 > 3'd2);
        end
        OPC_OP: begin
          b_sel = OP_B_RS2;
          alu   = {2'b00, f7[5], f3};
          gwe   = 1'b1;
          ill   = !((f7 == 7'h00) ||
                    ((f7 == 7'h20) &&
                     ((f3 == 3'd0) ||
                      (f3 == 3'd5))));
        end
        OPC_OP_IMM: begin
          alu = {2'b00,
                 (f3 == 3'd5) && f7[5], f3};
          gwe = 1'b1;
          if (f3 == 3'd1)
            ill = (f7 != 7'h00);
          else if (f3 == 3'd5)
            ill = (f7 != 7'h00) &&
                  (f7 != 7'h20);
        end
        OPC_LUI: begin
          a_sel = OP_A_ZERO;
          b_sel = OP_B_IMM_U;
          gwe   = 1'b1;
        end
        OPC_AUIPC: begin
          a_sel = OP_A_CURR_PC;
          b_sel = OP_B_IMM_U;
          gwe   = 1'b1;
        end
        OPC_BRANCH: begin
          b_sel = OP_B_RS2;
          alu   = {2'b11, f3};
          br    = 1'b1;
          ill   = (f3 == 3'd2) || (f3 == 3'd3);
        end
        OPC_JAL: begin
          a_sel = OP_A_CURR_PC;
          b_sel = OP_B_INCR;
          gwe   = 1'b1;
          jal   = 1'b1;
        end
        OPC_JALR: begin
          a_sel = OP_A_CURR_PC;
          b_sel = OP_B_INCR;
          gwe   = 1'b1;
          jalr  = 1'b1;
          ill   = (f3 != 3'd0);
        end
        OPC_MISC, OPC_SYSTEM: begin
          ill = 1'b0;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      mreq = 1'b0;
      mwe  = 1'b0;
      gwe  = 1'b0;
      br   = 1'b0;
      jal  = 1'b0;
      jalr = 1'b0;
    end
  end

  // Output stage: load on free slot, hold on stall
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid            <= 1'b0;
      bus.dec_instr_o      <= '0;
      bus.dec_pc_o         <= '0;
      bus.ex_op_a_sel_o    <= OP_A_RS1;
      bus.ex_op_b_sel_o    <= OP_B_IMM_I;
      bus.alu_op_o         <= ALU_ADD;
      bus.mem_req_o        <= 1'b0;
      bus.mem_we_o         <= 1'b0;
      bus.mem_size_o       <= LDST_B;
      bus.gpr_we_a_o       <= 1'b0;
      bus.wb_src_sel_o     <= WB_EX;
      bus.illegal_instr_o  <= 1'b0;
      bus.branch_o         <= 1'b0;
      bus.jal_o            <= 1'b0;
      bus.jalr_o           <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid            <= 1'b1;
      bus.dec_instr_o      <= head;
      bus.dec_pc_o         <= pc_q[rd_ptr];
      bus.ex_op_a_sel_o    <= a_sel;
      bus.ex_op_b_sel_o    <= b_sel;
      bus.alu_op_o         <= alu;
      bus.mem_req_o        <= mreq;
      bus.mem_we_o         <= mwe;
      bus.mem_size_o       <= size;
      bus.gpr_we_a_o       <= gwe;
      bus.wb_src_sel_o     <= wb;
      bus.illegal_instr_o  <= ill;
      bus.branch_o         <= br;
      bus.jal_o            <= jal;
      bus.jalr_o           <= jalr;
    end else if (bus.out_ready_i) begin
      out_valid <= 1'b0;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.count_o     = cnt;
endmodule

// File: tb/tb_decoder_riscv_pipe.sv
// Directed bench for decoder_riscv_pipe:
// decode table plus stall, flush and stream runs.
module tb_decoder_riscv_pipe;
  logic clk = 1'b0;
  logic rst, flush;
  int checks = 0;
  int errors = 0;

  decoder_riscv_pipe_if #(.DEPTH(4), .PC_W(32)) bus();

  decoder_riscv_pipe #(.DEPTH(4), .PC_W(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [20:0] exp;
    logic        full;
  } vec_t;

  localparam logic [20:0] ILL_MASK = 21'h0062F;

  vec_t vecs [23];

  function automatic logic [20:0] mk(
    input logic [1:0] a, input logic [2:0] b,
    input logic [4:0] alu, input logic mreq,
    input logic mwe, input logic [2:0] size,
    input logic gwe, input logic wb,
    input logic ill, input logic br,
    input logic jl, input logic jr);
    return {a, b, alu, mreq, mwe, size,
            gwe, wb, ill, br, jl, jr};
  endfunction

  function automatic logic [20:0] got();
    return {bus.ex_op_a_sel_o, bus.ex_op_b_sel_o,
            bus.alu_op_o, bus.mem_req_o,
            bus.mem_we_o, bus.mem_size_o,
            bus.gpr_we_a_o, bus.wb_src_sel_o,
            bus.illegal_instr_o, bus.branch_o,
            bus.jal_o, bus.jalr_o};
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic chk_dec(input string name,
                         input int idx);
    logic [20:0] m;
    m = vecs[idx].full ? '1 : ILL_MASK;
    checks++;
    if ((got() & m) !== (vecs[idx].exp & m) ||
        bus.dec_instr_o !== vecs[idx].instr) begin
      errors++;
      $display("FAIL %s[%0d] instr %h: got %h/%h expected %h/%h",
               name, idx, vecs[idx].instr,
               bus.dec_instr_o, got() & m,
               vecs[idx].instr, vecs[idx].exp & m);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins,
                      input logic [31:0] pc);
    bus.in_valid_i = 1'b1;
    bus.instr_i    = ins;
    bus.pc_i       = pc;
    step();
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (bus.out_valid_o !== 1'b1 && n < 10) begin
      step();
      n++;
    end
    if (n >= 10) begin
      checks++;
      errors++;
      $display("FAIL %s: out_valid timeout", name);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00412083,
                 mk(0,1,0,1,0,2,1,1,0,0,0,0), 1};
    vecs[1]  = '{32'h00112423,
                 mk(0,3,0,1,1,2,0,0,0,0,0,0), 1};
    vecs[2]  = '{32'h00014083,
                 mk(0,1,0,1,0,4,1,1,0,0,0,0), 1};
    vecs[3]  = '{32'h002081B3,
                 mk(0,0,0,0,0,0,1,0,0,0,0,0), 1};
    vecs[4]  = '{32'h402081B3,
                 mk(0,0,8,0,0,0,1,0,0,0,0,0), 1};
    vecs[5]  = '{32'h4020D1B3,
                 mk(0,0,13,0,0,0,1,0,0,0,0,0), 1};
    vecs[6]  = '{32'h40315093,
                 mk(0,1,13,0,0,0,1,0,0,0,0,0), 1};
    vecs[7]  = '{32'hFFF10093,
                 mk(0,1,0,0,0,0,1,0,0,0,0,0), 1};
    vecs[8]  = '{32'h123452B7,
                 mk(2,2,0,0,0,0,1,0,0,0,0,0), 1};
    vecs[9]  = '{32'h00001297,
                 mk(1,2,0,0,0,0,1,0,0,0,0,0), 1};
    vecs[10] = '{32'h00208463,
                 mk(0,0,24,0,0,0,0,0,0,1,0,0), 1};
    vecs[11] = '{32'h0020D463,
                 mk(0,0,29,0,0,0,0,0,0,1,0,0), 1};
    vecs[12] = '{32'h010000EF,
                 mk(1,4,0,0,0,0,1,0,0,0,1,0), 1};
    vecs[13] = '{32'h000100E7,
                 mk(1,4,0,0,0,0,1,0,0,0,0,1), 1};
    vecs[14] = '{32'h0000000F,
                 mk(0,1,0,0,0,0,0,0,0,0,0,0), 1};
    vecs[15] = '{32'h00000073,
                 mk(0,1,0,0,0,0,0,0,0,0,0,0), 1};
    vecs[16] = '{32'h00003003,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};
    vecs[17] = '{32'h40001033,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};
    vecs[18] = '{32'h00000000,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};
    vecs[19] = '{32'h40111093,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};
    vecs[20] = '{32'h0020A463,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};
    vecs[21] = '{32'h000110E7,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};
    vecs[22] = '{32'h00113423,
                 mk(0,0,0,0,0,0,0,0,1,0,0,0), 0};

    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.instr_i     = '0;
    bus.pc_i        = '0;
    bus.out_ready_i = 1'b0;

    // reset
    step();
    chk("rst_in_ready", 32'(bus.in_ready_o), 0);
    step();
    chk("rst_valid", 32'(bus.out_valid_o), 0);
    chk("rst_count", 32'(bus.count_o), 0);
    chk("rst_in_ready2", 32'(bus.in_ready_o), 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after", 32'(bus.in_ready_o), 1);

    // first lw: latency of two edges
    bus.out_ready_i = 1'b1;
    send(32'h00412083, 32'h100);
    chk("lat_valid_n", 32'(bus.out_valid_o), 0);
    chk("lat_count_n", 32'(bus.count_o), 1);
    step();
    chk("lat_valid_n1", 32'(bus.out_valid_o), 1);
    chk("lat_pc", bus.dec_pc_o, 32'h100);
    chk_dec("lw", 0);
    step();
    chk("lw_consumed", 32'(bus.out_valid_o), 0);

    // decode table
    for (int i = 0; i < 23; i++) begin
      send(vecs[i].instr, 32'h1000 + 32'(i * 4));
      wait_valid("table");
      chk_dec("table", i);
      chk("table_pc", bus.dec_pc_o,
          32'h1000 + 32'(i * 4));
      step();
    end

    // stall: 5 pushes fill output stage + FIFO
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(bus.in_ready_o), 1);
      send(32'h00000093 | (32'(i) << 20),
           32'h200 + 32'(i * 4));
    end
    chk("stall_count", 32'(bus.count_o), 4);
    chk("stall_full", 32'(bus.in_ready_o), 0);
    for (int c = 0; c < 3; c++) begin
      chk("stall_valid", 32'(bus.out_valid_o), 1);
      chk("stall_hold", bus.dec_instr_o,
          32'h00000093);
      chk("stall_hold_pc", bus.dec_pc_o, 32'h200);
      step();
    end
    bus.out_ready_i = 1'b1;
    begin
      int k = 0;
      for (int c = 0; c < 12; c++) begin
        if (bus.out_valid_o) begin
          chk("stall_order", bus.dec_pc_o,
              32'h200 + 32'(k * 4));
          k++;
        end
        step();
      end
      chk("stall_total", 32'(k), 5);
    end

    // flush with 3 queued and a coincident push
    bus.out_ready_i = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h002081B3, 32'h300 + 32'(i * 4));
    chk("pre_flush_count", 32'(bus.count_o), 3);
    chk("pre_flush_valid", 32'(bus.out_valid_o), 1);
    flush = 1'b1;
    send(32'h00208463, 32'h400);
    flush = 1'b0;
    chk("flush_count", 32'(bus.count_o), 0);
    chk("flush_valid", 32'(bus.out_valid_o), 0);
    bus.out_ready_i = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        if (bus.out_valid_o) seen++;
        step();
      end
      chk("flush_nothing", 32'(seen), 0);
    end

    // back-to-back stream: add beq jal jalr lui
    begin
      int idx [5] = '{3, 10, 12, 13, 8};
      int k = 0;
      int first = -1;
      int last = -1;
      for (int c = 0; c < 12; c++) begin
        if (c < 5) begin
          bus.in_valid_i = 1'b1;
          bus.instr_i    = vecs[idx[c]].instr;
          bus.pc_i       = 32'h500 + 32'(c * 4);
        end else begin
          bus.in_valid_i = 1'b0;
        end
        step();
        if (bus.out_valid_o && k < 5) begin
          chk_dec("stream", idx[k]);
          if (first < 0) first = c;
          last = c;
          k++;
        end
      end
      chk("stream_total", 32'(k), 5);
      chk("stream_first", 32'(first), 1);
      chk("stream_gapless", 32'(last - first), 4);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
